// File: rtl/vec3_pkg.sv
// vec3_pkg: shared types and constants for the sequenced vec3 length unit.
// Holds the packed vec3 bundle, the FSM state encoding and the Q-format unit.
package vec3_pkg;

  localparam int VEC_W  = 32;
  localparam int FRAC_W = 24;
  localparam logic [VEC_W-1:0] Q_ONE = 32'(1) << FRAC_W;

  typedef struct packed {
    logic [VEC_W-1:0] x;
    logic [VEC_W-1:0] y;
    logic [VEC_W-1:0] z;
  } vec3_t;

  typedef enum logic [2:0] {
    IDLE,
    SQX,
    SQY,
    SQZ,
    ROOT,
    DONE
  } state_e;

endpackage

// File: rtl/vec3_length_seq_usqrt_step.sv
// usqrt_step: one restoring square-root iteration (combinational).
// Brings in two radicand bits, tries (root<<2)|1 and keeps it if it fits.
module usqrt_step #(
  parameter int N = 32
) (
  input  logic [N+1:0] rem_i,
  input  logic [N-1:0] root_i,
  input  logic [1:0]   bits_i,
  output logic [N+1:0] rem_o,
  output logic [N-1:0] root_o
);

  logic [N+3:0] rem_sh;
  logic [N+3:0] trial;
  logic [N+3:0] diff;

  // Shift in the next radicand pair and attempt the trial subtraction.
  always_comb begin
    rem_sh = {rem_i, bits_i};
    trial  = {2'b00, root_i, 2'b01};
    diff   = rem_sh - trial;
    if (rem_sh >= trial) begin
      rem_o  = diff[N+1:0];
      root_o = {root_i[N-2:0], 1'b1};
    end else begin
      rem_o  = rem_sh[N+1:0];
      root_o = {root_i[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/vec3_length_seq.sv
// vec3_length_seq: floor(sqrt(x^2+y^2+z^2)) with one shared multiplier
// and a bit-serial restoring sqrt. Option macro: VEC3_LEN_EARLY_ZERO_EN.
module vec3_length_seq
  import vec3_pkg::*;
#(
  parameter int N    = 32,
  parameter int FRAC = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3*N-1:0] vec,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   length,
  output logic           busy
);

  localparam int CW = $clog2(N);

  if (FRAC >= N || FRAC < 0) begin : g_bad_frac
    $error("FRAC must lie in [0, N)");
  end

  state_e          state_q;
  logic [3*N-1:0]  vec_q;
  logic [2*N-1:0]  acc_q;
  logic [2*N-1:0]  acc_d;
  logic [2*N-1:0]  op_q;
  logic [N+1:0]    rem_q;
  logic [N+1:0]    rem_d;
  logic [N-1:0]    root_q;
  logic [N-1:0]    root_d;
  logic [N-1:0]    len_q;
  logic [CW-1:0]   cnt_q;
  logic            out_valid_q;

  logic [N-1:0]    comp;
  logic [2*N-1:0]  comp_ext;
  logic [2*N-1:0]  sq;

  // Pick the component for this square cycle and square it (exact in 2N bits).
  always_comb begin
    comp = vec_q[3*N-1:2*N];
    if (state_q == SQY) comp = vec_q[2*N-1:N];
    if (state_q == SQZ) comp = vec_q[N-1:0];
    comp_ext = {{N{comp[N-1]}}, comp};
    sq       = comp_ext * comp_ext;
    acc_d    = acc_q + sq;
  end

  usqrt_step #(.N(N)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (op_q[2*N-1:2*N-2]),
    .rem_o  (rem_d),
    .root_o (root_d)
  );

  // Main sequencer: accept, accumulate squares, iterate sqrt, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      acc_q       <= '0;
      op_q        <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_q   <= vec;
            acc_q   <= '0;
            state_q <= SQX;
          end
        end
        SQX: begin
          acc_q   <= acc_d;
          state_q <= SQY;
        end
        SQY: begin
          acc_q   <= acc_d;
          state_q <= SQZ;
        end
        SQZ: begin
          acc_q  <= acc_d;
          op_q   <= acc_d;
          rem_q  <= '0;
          root_q <= '0;
          cnt_q  <= CW'(N-1);
`ifdef VEC3_LEN_EARLY_ZERO_EN
          if (acc_d == '0) begin
            len_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= ROOT;
          end
`else
          state_q <= ROOT;
`endif
        end
        ROOT: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          op_q   <= op_q << 2;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            len_q       <= root_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign length    = len_q;

endmodule
